// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Iterative controller for a single shared AES round datapath. It owns the
//   128-bit state register, walks the round counter and picks the round key
//   out of the expanded-key bus. The external round logic is combinational:
//   it sees st_q/rk/mode_q/last_round and hands back rnd_res.
//
// Optional build macro: AES_SEQ_ABORT_EN (adds the abort input).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input block handshake; in_mode/din sampled on accept
//   key_exp           expanded key, round key 0 in the MSBs
//   st_q, rk          current state and round key towards the round logic
//   rnd_idx           round number 1..NR while rounding, else 0
//   last_round        final round flag (no (Inv)MixColumns)
//   mode_q            latched direction, 0 = encrypt, 1 = decrypt
//   rnd_res           round result from the external round logic
//   out_valid/out_ready/dout  result handshake, dout == st_q
//   busy              high while a block is being processed or held
//   abort             (AES_SEQ_ABORT_EN only) drop the current block

module aes_round_sequencer #(
  parameter int NR = 14,
  parameter int CW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [127:0]          din,
  input  logic [128*(NR+1)-1:0] key_exp,
  output logic [127:0]          st_q,
  output logic [127:0]          rk,
  output logic [CW-1:0]         rnd_idx,
  output logic                  last_round,
  output logic                  mode_q,
  input  logic [127:0]          rnd_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          dout,
`ifdef AES_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy
);

  localparam logic [CW-1:0] NR_C = CW'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [127:0]  r_st;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic          w_abort;
  logic          w_in_round;
  logic [CW-1:0] w_key_sel;
  logic [127:0]  w_rk_tbl [0:NR];

`ifdef AES_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Slice the expanded-key bus into one entry per round key.
  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_rk
      assign w_rk_tbl[gi] = key_exp[128*(NR+1)-1-128*gi -: 128];
    end
  endgenerate

  assign w_in_round = (r_state == S_ROUND);

  // Key index: in IDLE it follows the live in_mode so the whitening XOR on
  // accept uses the right key; while rounding decrypt walks keys downwards.
  // Outside those states it shows the key of the final round just done.
  always_comb begin
    w_key_sel = '0;
    case (r_state)
      S_IDLE:  w_key_sel = in_mode ? NR_C : '0;
      S_ROUND: w_key_sel = r_mode ? (NR_C - r_cnt) : r_cnt;
      default: w_key_sel = r_mode ? '0 : NR_C;
    endcase
  end

  assign rk         = w_rk_tbl[w_key_sel];
  assign st_q       = r_st;
  assign dout       = r_st;
  assign mode_q     = r_mode;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign rnd_idx    = w_in_round ? r_cnt : '0;
  assign last_round = w_in_round && (r_cnt == NR_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort is deliberately not looked at here.
          if (in_valid) begin
            r_st       <= din ^ rk;
            r_mode     <= in_mode;
            r_cnt      <= CW'(1);
            r_state    <= S_ROUND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_ROUND: begin
          if (w_abort) begin
            // st_q keeps its last value; only control state is dropped.
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_st <= rnd_res;
            if (r_cnt >= NR_C) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Leaving DONE raises in_ready only for the following cycle, which
          // is what produces the single bubble between blocks.
          if (w_abort || out_ready) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  localparam int NR = 14;
  localparam int CW = 4;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [127:0]          din;
  logic [128*(NR+1)-1:0] key_exp;
  logic [127:0]          st_q;
  logic [127:0]          rk;
  logic [CW-1:0]         rnd_idx;
  logic                  last_round;
  logic                  mode_q;
  logic [127:0]          rnd_res;
  logic                  out_valid;
  logic                  out_ready;
  logic [127:0]          dout;
  logic                  busy;
`ifdef AES_SEQ_ABORT_EN
  logic                  abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rks   [NR+1];

  aes_round_sequencer #(.NR(NR), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .din        (din),
    .key_exp    (key_exp),
    .st_q       (st_q),
    .rk         (rk),
    .rnd_idx    (rnd_idx),
    .last_round (last_round),
    .mode_q     (mode_q),
    .rnd_res    (rnd_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
`ifdef AES_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
    return r;
  endfunction

  // Byte 4c+r is row r of column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        if (!inv) r[127-8*(4*c+w) -: 8] = gb(s, 4*((c+w)%4)+w);
        else      r[127-8*(4*((c+w)%4)+w) -: 8] = gb(s, 4*c+w);
      end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0] m [4];
    logic [7:0] o;
    if (!inv) begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    else      begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o ^= gm(gb(s, 4*c+j), m[(j-i+4)%4]);
        r[127-8*(4*c+i) -: 8] = o;
      end
    return r;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (!last) t = mix_cols(t, 1'b0);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (!last) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  // Whole-block cipher from the round key schedule.
  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ rks[0];
    for (int r = 1; r <= NR; r++) s = enc_round(s, rks[r], r == NR);
    return s;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [127:0] s = ct ^ rks[NR];
    for (int r = NR - 1; r >= 0; r--) s = dec_round(s, rks[r], r == 0);
    return s;
  endfunction

  // External combinational round logic feeding the sequencer.
  always_comb begin
    rnd_res = mode_q ? dec_round(st_q, rk, last_round) : enc_round(st_q, rk, last_round);
  end

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] p;
    for (int i = 0; i < 256; i++) begin
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gm(p, 8'(i));
      inv = (i == 0) ? 8'h00 : p;
      sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  // AES-256 key schedule; fills rks[] and drives key_exp (round 0 in MSBs).
  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r <= NR; r++) begin
      rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      key_exp[128*(NR+1)-1-128*r -: 128] = rks[r];
    end
  endtask

  // ---------------- bench helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full block with per-round checks, hold cycles of output backpressure
  // (in_valid held high meanwhile), then the output handshake.
  task automatic run_block(input logic [127:0] blk, input logic m, input logic [127:0] exp_out, input int hold);
    logic [127:0] held;
    in_valid = 1'b1; din = blk; in_mode = m; out_ready = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_rk", rk, m ? rks[NR] : rks[0]);
    tick();
    in_valid = 1'b0;
    din = {$urandom, $urandom, $urandom, $urandom};
    check("acc_mode_q", mode_q, m);
    for (int c = 1; c <= NR; c++) begin
      out_ready = 1'(($urandom & 1));
      #1;
      check("rnd_idx", rnd_idx, c);
      check("rnd_rk", rk, m ? rks[NR-c] : rks[c]);
      check("last_round", last_round, (c == NR));
      check("rnd_out_valid", out_valid, 0);
      check("rnd_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b0;
    check("done_out_valid", out_valid, 1);
    check("done_dout", dout, exp_out);
    check("done_busy", busy, 1);
    held = dout;
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_dout", dout, held);
      check("hold_in_ready", in_ready, 0);
      check("hold_mode_q", mode_q, m);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    $display("[TB] block mode=%0d din=%h dout=%h hold=%0d", m, blk, held, hold);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rnd_idx"}, rnd_idx, 0);
    check({tag, "_last_round"}, last_round, 0);
    check({tag, "_st_q"}, st_q, 0);
    check({tag, "_mode_q"}, mode_q, 0);
  endtask

  localparam logic [255:0] KEY_NIST = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_NIST  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_NIST  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] b_din [2];
    logic         b_mode [2];
    logic [127:0] b_exp [2];
    logic [127:0] pt;
    logic         m;
    logic         acc;
    int           idx_in;
    int           idx_out;
    int           last_acc;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; din = '0; out_ready = 1'b0;
    key_exp = '0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    init_sbox();
    expand_key(KEY_NIST);
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Known-answer encrypt and decrypt, the decrypt with 5 cycles backpressure.
    run_block(PT_NIST, 1'b0, CT_NIST, 0);
    run_block(CT_NIST, 1'b1, PT_NIST, 5);

    // Back-to-back with in_valid and out_ready held high.
    b_din[0] = PT_NIST; b_mode[0] = 1'b0; b_exp[0] = CT_NIST;
    b_din[1] = CT_NIST; b_mode[1] = 1'b1; b_exp[1] = PT_NIST;
    in_valid = 1'b1; din = b_din[0]; in_mode = b_mode[0]; out_ready = 1'b1;
    #1;
    idx_in = 0; idx_out = 0; last_acc = 0;
    for (int cyc = 0; cyc < 100 && idx_out < 2; cyc++) begin
      if (out_valid) begin
        check("b2b_dout", dout, b_exp[idx_out]);
        $display("[TB] b2b out %0d dout=%h", idx_out, dout);
        idx_out++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        check("b2b_mode_q", mode_q, b_mode[idx_in]);
        if (idx_in > 0) check("b2b_spacing", cyc - last_acc, NR + 2);
        last_acc = cyc;
        idx_in++;
        if (idx_in < 2) begin din = b_din[idx_in]; in_mode = b_mode[idx_in]; end
        else in_valid = 1'b0;
      end else if (idx_in == 1) begin
        check("b2b_mode_hold", mode_q, b_mode[0]);
      end
    end
    check("b2b_complete", idx_out, 2);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of the edge gap at round 7.
    in_valid = 1'b1; din = PT_NIST; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && rnd_idx != 7; k++) tick();
    check("rst_reach_r7", rnd_idx, 7);
    #3 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    $display("[TB] async reset at round 7");
    tick();
    rst = 1'b0;
    tick();
    run_block(PT_NIST, 1'b0, CT_NIST, 1);

    // Random keys, blocks, modes and backpressure against the reference model.
    for (int n = 0; n < 8; n++) begin
      expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      m  = 1'(($urandom & 1));
      run_block(pt, m, m ? ref_dec(pt) : ref_enc(pt), int'($urandom_range(0, 3)));
    end

`ifdef AES_SEQ_ABORT_EN
    begin
      logic [127:0] st_before;
      logic         saw_valid;
      expand_key(KEY_NIST);
      in_valid = 1'b1; din = PT_NIST; in_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 20 && rnd_idx != 5; k++) tick();
      check("abort_reach_r5", rnd_idx, 5);
      abort = 1'b1;
      st_before = st_q;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_rnd_idx", rnd_idx, 0);
      check("abort_st_q", st_q, st_before);
      saw_valid = 1'b0;
      for (int k = 0; k < NR + 3; k++) begin
        tick();
        if (out_valid) saw_valid = 1'b1;
      end
      check("abort_no_valid", saw_valid, 0);
      $display("[TB] abort at round 5");
      // abort in IDLE coinciding with accept is ignored.
      abort = 1'b1; in_valid = 1'b1; din = PT_NIST; in_mode = 1'b0;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      check("abort_idle_busy", busy, 1);
      for (int k = 0; k < NR + 5 && !out_valid; k++) tick();
      check("abort_idle_valid", out_valid, 1);
      check("abort_idle_dout", dout, CT_NIST);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      $display("[TB] abort in idle with accept");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
